// File: rtl/mux_scan_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_sequencer_pkg
// Description : Shared state encodings and channel constants for the scan
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_scan_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam int         c_num_channels = 4;
    localparam logic [1:0] c_last_channel = 2'd3;

endpackage : mux_scan_sequencer_pkg
`default_nettype wire

// File: rtl/mux_scan_sequencer_settle_timer.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_sequencer_settle_timer
// Description : Loadable count-down timer; done is high while the count is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_sequencer_settle_timer
    import mux_scan_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam int                CNT_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_reload = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // The count saturates at zero so an idle enable can never wrap it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= c_reload;
        end else if (en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign done = (r_cnt == '0);

endmodule : mux_scan_sequencer_settle_timer
`default_nettype wire

// File: rtl/mux_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_sequencer
// Description : Steps a 4:1 mux through its channels, samples each after a
//               settle interval and presents the 4-bit word over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_sequencer
    import mux_scan_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      continuous,
    input  logic                      mux_out,
    output logic                      addr0,
    output logic                      addr1,
    output logic                      sample_strb,
    output logic [c_num_channels-1:0] word,
    output logic                      word_valid,
    input  logic                      word_ready,
    output logic                      busy
);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [1:0]                r_addr;
    logic [c_num_channels-1:0] r_word;
    logic                      r_valid;

    logic w_timer_load;
    logic w_timer_en;
    logic w_timer_done;
    logic w_capture;
    logic w_addr_inc;
    logic w_valid_set;
    logic w_release;

    mux_scan_sequencer_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk  (clk),
        .rst  (reset),
        .load (w_timer_load),
        .en   (w_timer_en),
        .done (w_timer_done)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_timer_load = 1'b0;
        w_timer_en   = 1'b0;
        w_capture    = 1'b0;
        w_addr_inc   = 1'b0;
        w_valid_set  = 1'b0;
        w_release    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt  = ST_SETTLE;
                    w_timer_load = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (w_timer_done) begin
                    w_state_nxt = ST_SAMPLE;
                end else begin
                    w_timer_en = 1'b1;
                end
            end
            ST_SAMPLE: begin
                w_capture = 1'b1;
                if (r_addr == c_last_channel) begin
                    w_state_nxt = ST_HOLD;
                    w_valid_set = 1'b1;
                end else begin
                    w_state_nxt  = ST_SETTLE;
                    w_addr_inc   = 1'b1;
                    w_timer_load = 1'b1;
                end
            end
            ST_HOLD: begin
                // The word stays frozen until the consumer accepts it.
                if (word_ready) begin
                    w_release = 1'b1;
                    if (continuous) begin
                        w_state_nxt  = ST_SETTLE;
                        w_timer_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_addr  <= 2'd0;
            r_word  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_addr_inc) begin
                r_addr <= r_addr + 2'd1;
            end else if (w_release) begin
                r_addr <= 2'd0;
            end

            if (w_capture) begin
                r_word[r_addr] <= mux_out;
            end

            if (w_valid_set) begin
                r_valid <= 1'b1;
            end else if (w_release) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign addr0       = r_addr[0];
    assign addr1       = r_addr[1];
    assign word        = r_word;
    assign word_valid  = r_valid;
    assign sample_strb = (r_state == ST_SAMPLE);
    assign busy        = (r_state != ST_IDLE);

endmodule : mux_scan_sequencer
`default_nettype wire

// File: tb/tb_mux_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan_sequencer
// Description : Directed self-checking bench; two instances cover the default
//               and a longer settle interval.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       a_start, a_cont, a_ready, a_mux;
    logic       a_addr0, a_addr1, a_strb, a_valid, a_busy;
    logic [3:0] a_word, a_in;
    logic       b_start, b_cont, b_ready, b_mux;
    logic       b_addr0, b_addr1, b_strb, b_valid, b_busy;
    logic [3:0] b_word, b_in;

    // Behavioural 4:1 mux in front of each sequencer
    assign a_mux = a_in[{a_addr1, a_addr0}];
    assign b_mux = b_in[{b_addr1, b_addr0}];

    mux_scan_sequencer #(.SETTLE_CYCLES(1)) u_dut_a (
        .clk         (clk),
        .reset       (reset),
        .start       (a_start),
        .continuous  (a_cont),
        .mux_out     (a_mux),
        .addr0       (a_addr0),
        .addr1       (a_addr1),
        .sample_strb (a_strb),
        .word        (a_word),
        .word_valid  (a_valid),
        .word_ready  (a_ready),
        .busy        (a_busy)
    );

    mux_scan_sequencer #(.SETTLE_CYCLES(3)) u_dut_b (
        .clk         (clk),
        .reset       (reset),
        .start       (b_start),
        .continuous  (b_cont),
        .mux_out     (b_mux),
        .addr0       (b_addr0),
        .addr1       (b_addr1),
        .sample_strb (b_strb),
        .word        (b_word),
        .word_valid  (b_valid),
        .word_ready  (b_ready),
        .busy        (b_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"},  32'({a_addr1, a_addr0}), 32'd0);
        check({tag, "_word"},  32'(a_word),  32'd0);
        check({tag, "_valid"}, 32'(a_valid), 32'd0);
        check({tag, "_strb"},  32'(a_strb),  32'd0);
        check({tag, "_busy"},  32'(a_busy),  32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        a_start = 1'b0; a_cont = 1'b0; a_ready = 1'b0; a_in = 4'b0000;
        b_start = 1'b0; b_cont = 1'b0; b_ready = 1'b0; b_in = 4'b0000;
        tick();
        tick();
        reset = 1'b0;
        check_all_zero("por");
        check("por_b_busy", 32'(b_busy), 32'd0);

        // Reset in the middle of the channel-2 settle
        a_in = 4'b1111;
        a_start = 1'b1; tick(); a_start = 1'b0;
        repeat (4) tick();
        check("t1_addr", 32'({a_addr1, a_addr0}), 32'd2);
        check("t1_busy", 32'(a_busy), 32'd1);
        check("t1_partial", 32'(a_word), 32'b0011);
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        check_all_zero("t1_rst");

        // Single scan, default settle
        a_in = 4'b1010;
        a_start = 1'b1; tick(); a_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("t2_addr",  32'({a_addr1, a_addr0}), i / 2);
            check("t2_strb",  32'(a_strb), i % 2);
            check("t2_valid", 32'(a_valid), 32'd0);
            tick();
        end
        check("t2_valid_rise", 32'(a_valid), 32'd1);
        check("t2_word", 32'(a_word), 32'b1010);
        check("t2_addr_hold", 32'({a_addr1, a_addr0}), 32'd3);

        // Backpressure in HOLD
        a_in = 4'b0101;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_valid", 32'(a_valid), 32'd1);
            check("t3_word", 32'(a_word), 32'b1010);
        end
        a_ready = 1'b1; tick(); a_ready = 1'b0;
        check("t3_valid_drop", 32'(a_valid), 32'd0);
        check("t3_busy", 32'(a_busy), 32'd0);
        check("t3_addr", 32'({a_addr1, a_addr0}), 32'd0);

        // Inputs change right after the channel-1 sample edge
        a_in = 4'b0000;
        a_start = 1'b1; tick(); a_start = 1'b0;
        repeat (4) tick();
        a_in = 4'b1111;
        repeat (4) tick();
        check("t6_valid", 32'(a_valid), 32'd1);
        check("t6_word", 32'(a_word), 32'b1100);
        a_ready = 1'b1; tick(); a_ready = 1'b0;
        check("t6_busy", 32'(a_busy), 32'd0);
        reset = 1'b1; tick(); reset = 1'b0;
        check("t6_word_clr", 32'(a_word), 32'd0);

        // Continuous back-to-back scans with stray start pulses
        a_in = 4'b1100; a_cont = 1'b1; a_ready = 1'b1;
        a_start = 1'b1; tick(); a_start = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            a_start = 1'b1; tick(); a_start = 1'b0;
            repeat (5) tick();
            check("t4_valid_pre", 32'(a_valid), 32'd0);
            check("t4_addr_last", 32'({a_addr1, a_addr0}), 32'd3);
            tick();
            check("t4_valid", 32'(a_valid), 32'd1);
            check("t4_word", 32'(a_word), 32'b1100);
            if (s == 2) a_cont = 1'b0;
            tick();
            check("t4_valid_drop", 32'(a_valid), 32'd0);
            check("t4_addr_rst", 32'({a_addr1, a_addr0}), 32'd0);
            check("t4_busy", 32'(a_busy), (s == 2) ? 32'd0 : 32'd1);
        end
        a_ready = 1'b0;

        // Longer settle interval on the second instance
        b_in = 4'b0110;
        b_start = 1'b1; tick(); b_start = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("t5_strb",  32'(b_strb),  32'((i % 4) == 3));
            check("t5_valid", 32'(b_valid), 32'(i == 16));
        end
        check("t5_word", 32'(b_word), 32'b0110);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mux_scan_sequencer
`default_nettype wire
